// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour replay path: FSM states,
// command opcodes, compass headings and default response bytes.
package tour_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VERT,
      WAIT_V,
      HORZ,
      WAIT_H
   } state_t;

   localparam logic [3:0] OP_MOVE     = 4'h2;
   localparam logic [3:0] OP_MOVE_FAN = 4'h3;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   localparam logic [7:0] RESP_ACK_DEF = 8'hA5;
   localparam logic [7:0] RESP_POS_DEF = 8'h5A;

   function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                          input logic [7:0] hdg,
                                          input logic [3:0] sq);
      return {op, hdg, sq};
   endfunction

endpackage

// File: rtl/tour_move_sequencer_if.sv
// Command-processor bus: command/valid out, clear/response-strobe back, and
// the response byte handed to the UART transmitter.
interface tour_move_sequencer_if;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;

   modport master (output cmd, cmd_rdy, resp, input clr_cmd_rdy, send_resp);
   modport slave  (input cmd, cmd_rdy, resp, output clr_cmd_rdy, send_resp);
endinterface

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into a vertical and a horizontal motion command.
// Build option TOUR_SEQ_FANFARE_EN: horizontal leg carries the move+fanfare opcode.
module tour_move_decode
   import tour_pkg::*;
(
   input  logic [7:0]  move,
   output logic [15:0] vert_cmd,
   output logic [15:0] horz_cmd,
   output logic        valid
);

`ifdef TOUR_SEQ_FANFARE_EN
   localparam logic [3:0] OP_H = OP_MOVE_FAN;
`else
   localparam logic [3:0] OP_H = OP_MOVE;
`endif

   logic [7:0] v_hdg, h_hdg;
   logic [3:0] v_sq, h_sq;

   always_comb begin
      // exactly one bit set: nonzero and clearing the lowest set bit leaves nothing
      valid = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
      v_hdg = HDG_N;
      v_sq  = 4'd0;
      h_hdg = HDG_E;
      h_sq  = 4'd0;
      case (move)
         8'h01:   begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end
         8'h02:   begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end
         8'h04:   begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end
         8'h08:   begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end
         8'h10:   begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end
         8'h20:   begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end
         8'h40:   begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end
         8'h80:   begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end
         default: begin v_hdg = HDG_N; v_sq = 4'd0; h_hdg = HDG_E; h_sq = 4'd0; end
      endcase
   end

   assign vert_cmd = mk_cmd(OP_MOVE, v_hdg, v_sq);
   assign horz_cmd = mk_cmd(OP_H, h_hdg, h_sq);

endmodule

// File: rtl/tour_move_sequencer.sv
// Replays a solved knight's tour as vertical/horizontal motion commands and
// muxes them with UART-sourced commands. Option: TOUR_SEQ_FANFARE_EN (see decoder).
module tour_move_sequencer
   import tour_pkg::*;
#(
   parameter int unsigned NUM_MOVES = 24,
   parameter logic [7:0]  RESP_ACK  = RESP_ACK_DEF,
   parameter logic [7:0]  RESP_POS  = RESP_POS_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_tour,
   input  logic [7:0]             move,
   output logic [4:0]             mv_indx,
   input  logic [15:0]            cmd_UART,
   input  logic                   cmd_rdy_UART,
   output logic                   clr_cmd_rdy_UART,
   tour_move_sequencer_if.master  cp,
   output logic                   tour_done,
   output logic                   tour_err
);

   localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

   state_t      state_q, state_d;
   logic [4:0]  mv_indx_q, mv_indx_d;
   logic [15:0] vert_cmd, horz_cmd;
   logic        mv_valid;

   tour_move_decode u_decode (
      .move     (move),
      .vert_cmd (vert_cmd),
      .horz_cmd (horz_cmd),
      .valid    (mv_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mv_indx_q <= 5'd0;
      end else begin
         state_q   <= state_d;
         mv_indx_q <= mv_indx_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      mv_indx_d        = mv_indx_q;
      cp.cmd           = vert_cmd;
      cp.cmd_rdy       = 1'b0;
      cp.resp          = RESP_POS;
      clr_cmd_rdy_UART = 1'b0;
      tour_done        = 1'b0;
      tour_err         = 1'b0;
      case (state_q)
         IDLE: begin
            cp.cmd           = cmd_UART;
            cp.cmd_rdy       = cmd_rdy_UART;
            clr_cmd_rdy_UART = cp.clr_cmd_rdy;
            cp.resp          = RESP_ACK;
            if (start_tour) begin
               mv_indx_d = 5'd0;
               state_d   = VERT;
            end
         end
         VERT: begin
            // a corrupt move is never offered to the command processor
            if (!mv_valid) begin
               tour_err = 1'b1;
               state_d  = IDLE;
            end else begin
               cp.cmd_rdy = 1'b1;
               if (cp.clr_cmd_rdy) state_d = WAIT_V;
            end
         end
         WAIT_V: begin
            if (cp.send_resp) state_d = HORZ;
         end
         HORZ: begin
            cp.cmd     = horz_cmd;
            cp.cmd_rdy = 1'b1;
            if (cp.clr_cmd_rdy) state_d = WAIT_H;
         end
         WAIT_H: begin
            cp.cmd = horz_cmd;
            if (cp.send_resp) begin
               if (mv_indx_q == LAST_INDX) begin
                  cp.resp   = RESP_ACK;
                  tour_done = 1'b1;
                  mv_indx_d = 5'd0;
                  state_d   = IDLE;
               end else begin
                  mv_indx_d = mv_indx_q + 5'd1;
                  state_d   = VERT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mv_indx = mv_indx_q;

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Directed bench for tour_move_sequencer: UART pass-through, full tour replay,
// bad-move abort and mid-tour reset, against hand-derived command words.
module tb_tour_move_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_tour = 1'b0;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART = 16'h0000;
   logic        cmd_rdy_UART = 1'b0;
   logic        clr_cmd_rdy_UART;
   logic        tour_done, tour_err;

   tour_move_sequencer_if cp();

   tour_move_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_tour       (start_tour),
      .move             (move),
      .mv_indx          (mv_indx),
      .cmd_UART         (cmd_UART),
      .cmd_rdy_UART     (cmd_rdy_UART),
      .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
      .cp               (cp),
      .tour_done        (tour_done),
      .tour_err         (tour_err)
   );

   always #5 clk = ~clk;

`ifdef TOUR_SEQ_FANFARE_EN
   localparam logic [3:0] OPH = 4'h3;
`else
   localparam logic [3:0] OPH = 4'h2;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0] mv_tab [0:23];
   logic       err_mode = 1'b0;

   // solver model: table lookup, with a corrupt two-hot move at index 5 in error mode
   always_comb begin
      move = 8'h00;
      if (mv_indx < 5'd24) move = mv_tab[mv_indx];
      if (err_mode && mv_indx == 5'd5) move = 8'h03;
   end

   int   rdy_cnt  = 0;
   int   done_cnt = 0;
   logic prev_rdy = 1'b0;

   always @(posedge clk) begin
      prev_rdy <= cp.cmd_rdy;
      if (cp.cmd_rdy && !prev_rdy) rdy_cnt <= rdy_cnt + 1;
      if (tour_done) done_cnt <= done_cnt + 1;
   end

   task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_vert(input logic [7:0] m);
      case (m)
         8'h01:   return 16'h2002;
         8'h02:   return 16'h2002;
         8'h04:   return 16'h2001;
         8'h08:   return 16'h27F1;
         8'h10:   return 16'h27F2;
         8'h20:   return 16'h27F2;
         8'h40:   return 16'h27F1;
         8'h80:   return 16'h2001;
         default: return 16'hxxxx;
      endcase
   endfunction

   function automatic logic [15:0] exp_horz(input logic [7:0] m);
      case (m)
         8'h01:   return {OPH, 12'hBF1};
         8'h02:   return {OPH, 12'h3F1};
         8'h04:   return {OPH, 12'h3F2};
         8'h08:   return {OPH, 12'h3F2};
         8'h10:   return {OPH, 12'h3F1};
         8'h20:   return {OPH, 12'hBF1};
         8'h40:   return {OPH, 12'hBF2};
         8'h80:   return {OPH, 12'hBF2};
         default: return 16'hxxxx;
      endcase
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Entered at posedge+1 of the cycle the FSM should sit in the leg state.
   task automatic do_leg(input string tag, input logic [15:0] exp_cmd, input int idx,
                         input logic last, input logic hold, input logic dual,
                         input logic poke, input logic stop);
      if (hold) begin
         @(negedge clk);
         chk_vec({tag, "_hold"}, cp.cmd_rdy, 1);
         cyc();
      end
      cp.clr_cmd_rdy = 1'b1;
      cp.send_resp   = dual;
      @(negedge clk);
      chk_vec({tag, "_rdy"}, cp.cmd_rdy, 1);
      chk_vec({tag, "_cmd"}, cp.cmd, exp_cmd);
      chk_vec({tag, "_idx"}, mv_indx, idx);
      chk_vec({tag, "_uclr"}, clr_cmd_rdy_UART, 0);
      cyc();
      cp.clr_cmd_rdy = 1'b0;
      cp.send_resp   = 1'b0;
      start_tour     = poke;
      @(negedge clk);
      chk_vec({tag, "_wrdy"}, cp.cmd_rdy, 0);
      chk_vec({tag, "_wresp"}, cp.resp, 8'h5A);
      if (stop) return;
      cyc();
      start_tour   = 1'b0;
      cp.send_resp = 1'b1;
      @(negedge clk);
      chk_vec({tag, "_resp"}, cp.resp, last ? 8'hA5 : 8'h5A);
      chk_vec({tag, "_done"}, tour_done, last);
      cyc();
      cp.send_resp = 1'b0;
   endtask

   task automatic begin_tour();
      cyc();
      start_tour = 1'b1;
      @(negedge clk);
      chk_vec("start_idle_rdy", cp.cmd_rdy, 0);
      cyc();
      start_tour = 1'b0;
   endtask

   initial begin
      logic [7:0] base [0:7];
      int rdy_base, done_base;
      base[0] = 8'h01; base[1] = 8'h10; base[2] = 8'h02; base[3] = 8'h04;
      base[4] = 8'h08; base[5] = 8'h20; base[6] = 8'h40; base[7] = 8'h80;
      for (int i = 0; i < 24; i++) mv_tab[i] = base[i % 8];
      cp.clr_cmd_rdy = 1'b0;
      cp.send_resp   = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_vec("rst_rdy", cp.cmd_rdy, 0);
      chk_vec("rst_idx", mv_indx, 0);
      chk_vec("rst_done", tour_done, 0);
      chk_vec("rst_err", tour_err, 0);
      chk_vec("rst_resp", cp.resp, 8'hA5);
      cyc();
      rst_n = 1'b1;

      // UART pass-through in IDLE
      cyc();
      cmd_UART     = 16'h2003;
      cmd_rdy_UART = 1'b1;
      @(negedge clk);
      chk_vec("uart_cmd", cp.cmd, 16'h2003);
      chk_vec("uart_rdy", cp.cmd_rdy, 1);
      chk_vec("uart_uclr0", clr_cmd_rdy_UART, 0);
      cyc();
      cp.clr_cmd_rdy = 1'b1;
      @(negedge clk);
      chk_vec("uart_uclr1", clr_cmd_rdy_UART, 1);
      cyc();
      cp.clr_cmd_rdy = 1'b0;
      cmd_rdy_UART   = 1'b0;

      // full replay with a UART command left pending throughout
      begin_tour();
      cmd_UART     = 16'h2114;
      cmd_rdy_UART = 1'b1;
      rdy_base     = rdy_cnt;
      done_base    = done_cnt;
      for (int i = 0; i < 24; i++) begin
         do_leg($sformatf("t1v%0d", i), exp_vert(mv_tab[i]), i, 1'b0,
                (i % 4) == 3, i == 2, i == 4, 1'b0);
         do_leg($sformatf("t1h%0d", i), exp_horz(mv_tab[i]), i, i == 23,
                1'b0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      chk_vec("t1_rdy_edges", rdy_cnt - rdy_base, 48);
      chk_vec("t1_done_pulses", done_cnt - done_base, 1);
      chk_vec("t1_end_resp", cp.resp, 8'hA5);
      chk_vec("t1_end_idx", mv_indx, 0);
      chk_vec("t1_fwd_cmd", cp.cmd, 16'h2114);
      chk_vec("t1_fwd_rdy", cp.cmd_rdy, 1);
      cyc();
      cp.clr_cmd_rdy = 1'b1;
      @(negedge clk);
      chk_vec("t1_fwd_uclr", clr_cmd_rdy_UART, 1);
      cyc();
      cp.clr_cmd_rdy = 1'b0;
      cmd_rdy_UART   = 1'b0;

      // corrupt move at index 5 aborts the tour
      err_mode = 1'b1;
      begin_tour();
      for (int i = 0; i < 5; i++) begin
         do_leg($sformatf("t2v%0d", i), exp_vert(mv_tab[i]), i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         do_leg($sformatf("t2h%0d", i), exp_horz(mv_tab[i]), i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      chk_vec("t2_err_pulse", tour_err, 1);
      chk_vec("t2_err_idx", mv_indx, 5);
      cyc();
      @(negedge clk);
      chk_vec("t2_err_clear", tour_err, 0);
      chk_vec("t2_idle_rdy", cp.cmd_rdy, 0);
      chk_vec("t2_idle_resp", cp.resp, 8'hA5);
      repeat (3) cyc();
      @(negedge clk);
      chk_vec("t2_no_more_rdy", cp.cmd_rdy, 0);
      err_mode = 1'b0;
      cyc();

      // reset asserted while waiting on the horizontal leg of move 10
      begin_tour();
      for (int i = 0; i < 10; i++) begin
         do_leg($sformatf("t3v%0d", i), exp_vert(mv_tab[i]), i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         do_leg($sformatf("t3h%0d", i), exp_horz(mv_tab[i]), i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      do_leg("t3v10", exp_vert(mv_tab[10]), 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_leg("t3h10", exp_horz(mv_tab[10]), 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_vec("t3_pre_idx", mv_indx, 10);
      #2;
      rst_n = 1'b0;
      #1;
      chk_vec("t3_rst_rdy", cp.cmd_rdy, 0);
      chk_vec("t3_rst_idx", mv_indx, 0);
      chk_vec("t3_rst_resp", cp.resp, 8'hA5);
      cyc();
      rst_n = 1'b1;
      cyc();
      @(negedge clk);
      chk_vec("t3_post_rdy", cp.cmd_rdy, 0);
      chk_vec("t3_post_done", tour_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
